// File: rtl/clocks_display_pkg.sv
// clocks_display_pkg
//   Shared constants for the timebase / seven-segment display block:
//   active-low segment patterns for BCD 0..9, the blank pattern, the
//   one-cold anode enables, the scan-position type and a BCD decoder.
package clocks_display_pkg;

    // Segment bit order: [0]=a .. [6]=g, [7]=dp. All active-low, dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One-cold digit enables; an[0] is the rightmost digit.
    localparam logic [3:0] AN_SEC_ONES = 4'b1110;
    localparam logic [3:0] AN_SEC_TENS = 4'b1101;
    localparam logic [3:0] AN_MIN_ONES = 4'b1011;
    localparam logic [3:0] AN_MIN_TENS = 4'b0111;
    localparam logic [3:0] AN_OFF      = 4'b1111;

    // Scan position, right to left.
    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_sel_e;

    // BCD to segment pattern; non-decimal codes show a blank digit.
    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] pattern;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/clocks_display_if.sv
// clocks_display_if
//   Bundles the BCD digit inputs, the exported square waves and the
//   seven-segment bus of clocks_display.
//   master : upstream counting logic / board side (drives BCD digits)
//   slave  : clocks_display (drives waves, an, seg)
//   min_tens, min_ones, sec_tens, sec_ones : BCD digits, MM:SS
//   clk_1hz, clk_5hz, clk_500hz            : 50% duty square waves
//   an  : active-low digit enables, an[0] = rightmost digit
//   seg : active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
interface clocks_display_if;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       clk_1hz;
    logic       clk_5hz;
    logic       clk_500hz;
    logic [3:0] an;
    logic [7:0] seg;

    modport master (
        output min_tens, min_ones, sec_tens, sec_ones,
        input  clk_1hz, clk_5hz, clk_500hz, an, seg
    );

    modport slave (
        input  min_tens, min_ones, sec_tens, sec_ones,
        output clk_1hz, clk_5hz, clk_500hz, an, seg
    );
endinterface

// File: rtl/clocks_display_clk_divider.sv
// clk_divider
//   Registered square-wave divider. A counter runs 0..HALF-1; on the
//   cycle it sits at HALF-1 it returns to 0 and the output toggles, so
//   the period is 2*HALF clk cycles and the first rising edge comes HALF
//   cycles after reset release.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   wave  : square-wave output, 0 in reset
//   rise  : high on the cycle whose closing edge takes wave 0->1
module clk_divider #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic wave,
    output logic rise
);
    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign rise    = at_last & ~wave;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (at_last) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/clocks_display.sv
// clocks_display
//   Timebase and 4-digit seven-segment driver. Three independent dividers
//   produce 1 Hz, 5 Hz and 500 Hz square waves; the 500 Hz one also paces
//   a 2-bit scan index that multiplexes MM:SS onto one active-low
//   anode/segment bus. an/seg are registered, one cycle behind the index
//   and the BCD inputs.
//   clk   : 100 MHz system clock (only clock)
//   rst_n : synchronous active-low reset
//   bus   : clocks_display_if.slave (BCD in, waves/an/seg out)
module clocks_display
    import clocks_display_pkg::*;
#(
    parameter int unsigned HALF_1HZ   = 50_000_000,
    parameter int unsigned HALF_5HZ   = 10_000_000,
    parameter int unsigned HALF_500HZ = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    clocks_display_if.slave   bus
);
    logic wave_1hz, wave_5hz, wave_500hz;
    logic rise_1hz, rise_5hz, rise_500hz;
    logic unused_rise;

    // Only the scan rate's rising-edge strobe is consumed here.
    assign unused_rise = rise_1hz ^ rise_5hz;

    clk_divider #(.HALF(HALF_1HZ)) u_div_1hz (
        .clk   (clk),
        .rst_n (rst_n),
        .wave  (wave_1hz),
        .rise  (rise_1hz)
    );

    clk_divider #(.HALF(HALF_5HZ)) u_div_5hz (
        .clk   (clk),
        .rst_n (rst_n),
        .wave  (wave_5hz),
        .rise  (rise_5hz)
    );

    clk_divider #(.HALF(HALF_500HZ)) u_div_500hz (
        .clk   (clk),
        .rst_n (rst_n),
        .wave  (wave_500hz),
        .rise  (rise_500hz)
    );

    assign bus.clk_1hz   = wave_1hz;
    assign bus.clk_5hz   = wave_5hz;
    assign bus.clk_500hz = wave_500hz;

    digit_sel_e idx;
    logic [3:0] an_next;
    logic [3:0] digit;
    logic [7:0] seg_next;
    logic [3:0] an_q;
    logic [7:0] seg_q;

    // Scan index advances on the same edge where clk_500hz goes 0->1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= DIG_SEC_ONES;
        end else if (rise_500hz) begin
            idx <= digit_sel_e'(idx + 2'd1);
        end
    end

    always_comb begin
        an_next = AN_SEC_ONES;
        digit   = bus.sec_ones;
        case (idx)
            DIG_SEC_ONES: begin an_next = AN_SEC_ONES; digit = bus.sec_ones; end
            DIG_SEC_TENS: begin an_next = AN_SEC_TENS; digit = bus.sec_tens; end
            DIG_MIN_ONES: begin an_next = AN_MIN_ONES; digit = bus.min_ones; end
            DIG_MIN_TENS: begin an_next = AN_MIN_TENS; digit = bus.min_tens; end
            default:      begin an_next = AN_OFF;      digit = '1;           end
        endcase
        seg_next = seg_decode(digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
endmodule

// File: tb/tb_clocks_display.sv
module tb_clocks_display;
    localparam int unsigned H1   = 20;
    localparam int unsigned H5   = 4;
    localparam int unsigned H500 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] mt = '0, mo = '0, st = '0, so = '0;
    clocks_display_if bus();
    assign bus.min_tens = mt;
    assign bus.min_ones = mo;
    assign bus.sec_tens = st;
    assign bus.sec_ones = so;

    clocks_display #(
        .HALF_1HZ   (H1),
        .HALF_5HZ   (H5),
        .HALF_500HZ (H500)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;                   // clock edges seen with rst_n high since last reset edge
    logic [3:0] c_mt, c_mo, c_st, c_so;   // BCD values present at the last edge

    // Reference model state
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_1, e_5, e_500;

    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Scan position shown after edge n: index value held just before edge n.
    // Index rises happen at edges H500, 3*H500, 5*H500, ...
    function automatic int ref_idx(input int k);
        return ((k - 1 + int'(H500)) / (2 * int'(H500))) % 4;
    endfunction

    function automatic logic ref_wave(input int k, input int unsigned h);
        return ((k / int'(h)) % 2) == 1;
    endfunction

    task automatic model_eval();
        int i;
        logic [3:0] d;
        if (n == 0) begin
            e_an = 4'hF; e_seg = 8'hFF; e_1 = 1'b0; e_5 = 1'b0; e_500 = 1'b0;
        end else begin
            i = ref_idx(n);
            d = (i == 0) ? c_so : (i == 1) ? c_st : (i == 2) ? c_mo : c_mt;
            e_an  = ~(4'b0001 << i);
            e_seg = ref_seg(d);
            e_1   = ref_wave(n, H1);
            e_5   = ref_wave(n, H5);
            e_500 = ref_wave(n, H500);
        end
    endtask

    task automatic step();
        c_mt = mt; c_mo = mo; c_st = st; c_so = so;
        @(posedge clk);
        if (rst_n) n = n + 1; else n = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mt = 4'($urandom_range(0, 9)); mo = 4'($urandom_range(0, 9));
        st = 4'($urandom_range(0, 9)); so = 4'($urandom_range(0, 9));
        repeat (3) step();
        checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", bus.an); end
        checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want FF", bus.seg); end
        checks++; if (bus.clk_1hz !== 1'b0) begin errors++; $display("FAIL reset_1hz got %b want 0", bus.clk_1hz); end
        checks++; if (bus.clk_5hz !== 1'b0) begin errors++; $display("FAIL reset_5hz got %b want 0", bus.clk_5hz); end
        checks++; if (bus.clk_500hz !== 1'b0) begin errors++; $display("FAIL reset_500hz got %b want 0", bus.clk_500hz); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL release_an got %b want 1110", bus.an); end
        checks++; if (bus.seg !== ref_seg(c_so)) begin errors++; $display("FAIL release_seg got %h want %h", bus.seg, ref_seg(c_so)); end
    endtask

    // Continues from test_reset; every cycle the waves must follow floor(n/H) mod 2.
    task automatic test_dividers();
        while (n < 90) begin
            step();
            model_eval();
            checks++; if (bus.clk_500hz !== e_500) begin errors++; $display("FAIL div_500hz n=%0d got %b want %b", n, bus.clk_500hz, e_500); end
            checks++; if (bus.clk_5hz !== e_5) begin errors++; $display("FAIL div_5hz n=%0d got %b want %b", n, bus.clk_5hz, e_5); end
            checks++; if (bus.clk_1hz !== e_1) begin errors++; $display("FAIL div_1hz n=%0d got %b want %b", n, bus.clk_1hz, e_1); end
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_an [5];
        logic [7:0] want_seg [5];
        int k;
        want_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        want_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h99};
        rst_n = 1'b0;
        step();
        mt = 4'd1; mo = 4'd2; st = 4'd3; so = 4'd4;
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            step();
            if ((n % (2 * int'(H500))) == int'(H500)) begin
                checks++; if (bus.an !== want_an[k]) begin errors++; $display("FAIL scan_an[%0d] got %b want %b", k, bus.an, want_an[k]); end
                checks++; if (bus.seg !== want_seg[k]) begin errors++; $display("FAIL scan_seg[%0d] got %h want %h", k, bus.seg, want_seg[k]); end
                k++;
            end
        end
        checks++; if (k != 5) begin errors++; $display("FAIL scan_timeout got %0d want 5 rising edges", k); end
    endtask

    task automatic test_decode_sweep();
        logic [7:0] sweep [16];
        bit seen;
        sweep = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int v = 0; v < 16; v++) begin
            so = 4'(v);
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (ref_idx(n) == 0) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL sweep_timeout v=%0d got no idx0 slot want one within 20", v);
            end else if (bus.seg !== sweep[v] || bus.an !== 4'b1110) begin
                errors++; $display("FAIL sweep_seg v=%0d got an=%b seg=%h want an=1110 seg=%h", v, bus.an, bus.seg, sweep[v]);
            end
            checks++; if (bus.seg[7] !== 1'b1) begin errors++; $display("FAIL sweep_dp v=%0d got %b want 1", v, bus.seg[7]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 3) == 0) mt = 4'($urandom);
            if ($urandom_range(0, 3) == 0) mo = 4'($urandom);
            if ($urandom_range(0, 3) == 0) st = 4'($urandom);
            so = 4'($urandom);
            step();
            model_eval();
            checks++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.clk_1hz !== e_1 ||
                bus.clk_5hz !== e_5 || bus.clk_500hz !== e_500) begin
                errors++;
                $display("FAIL random n=%0d got an=%b seg=%h w=%b%b%b want an=%b seg=%h w=%b%b%b",
                         n, bus.an, bus.seg, bus.clk_1hz, bus.clk_5hz, bus.clk_500hz,
                         e_an, e_seg, e_1, e_5, e_500);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        // edge 23: index already at 2 and clk_1hz high
        for (int c = 0; c < 40 && n < 23; c++) begin
            so = 4'($urandom_range(0, 9));
            step();
        end
        checks++; if (n != 23) begin errors++; $display("FAIL midrst_setup got n=%0d want 23", n); end
        checks++; if (bus.clk_1hz !== 1'b1) begin errors++; $display("FAIL midrst_pre_1hz got %b want 1", bus.clk_1hz); end
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 8'hFF || bus.clk_1hz !== 1'b0 ||
            bus.clk_5hz !== 1'b0 || bus.clk_500hz !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values got an=%b seg=%h w=%b%b%b want an=1111 seg=FF w=000",
                     bus.an, bus.seg, bus.clk_1hz, bus.clk_5hz, bus.clk_500hz);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            mt = 4'($urandom); mo = 4'($urandom); st = 4'($urandom); so = 4'($urandom);
            step();
            model_eval();
            checks++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.clk_1hz !== e_1 ||
                bus.clk_5hz !== e_5 || bus.clk_500hz !== e_500) begin
                errors++;
                $display("FAIL midrst_restart n=%0d got an=%b seg=%h w=%b%b%b want an=%b seg=%h w=%b%b%b",
                         n, bus.an, bus.seg, bus.clk_1hz, bus.clk_5hz, bus.clk_500hz,
                         e_an, e_seg, e_1, e_5, e_500);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dividers();
        test_scan();
        test_decode_sweep();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clocks_display.md
Name: clocks_display

Overview:
- Combined timebase and 4-digit seven-segment driver for the 100 MHz board clock.
- Divides `clk` into 1 Hz, 5 Hz and 500 Hz square waves; these are exported for the counting logic upstream.
- Time-multiplexes four BCD digits (MM:SS) onto one active-low anode/segment bus, scanned at the 500 Hz rate.

Parameters:
- HALF_1HZ, 50_000_000, clk cycles per half-period of `clk_1hz`.
- HALF_5HZ, 10_000_000, clk cycles per half-period of `clk_5hz`.
- HALF_500HZ, 100_000, clk cycles per half-period of `clk_500hz` (scan rate).

Ports:
- clk  in  1  system clock, 100 MHz; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- min_tens  in  4  BCD, leftmost digit.
- min_ones  in  4  BCD.
- sec_tens  in  4  BCD.
- sec_ones  in  4  BCD, rightmost digit.
- clk_1hz  out  1  registered square wave, 50% duty.
- clk_5hz  out  1  registered square wave, 50% duty.
- clk_500hz  out  1  registered square wave, 50% duty.
- an  out  4  digit enables, active-low; an[0] = rightmost digit.
- seg  out  8  segments, active-low; seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- All state updates on posedge `clk`. Reset is synchronous and active-low: sampled only at posedge `clk` while `rst_n` = 0.
- Reset values:
  - all divider counters = 0;
  - `clk_1hz` = `clk_5hz` = `clk_500hz` = 0;
  - scan index = 0;
  - `an` = 4'b1111, `seg` = 8'hFF (display dark).
- Divider, one per output, width $clog2(HALF_x):
  - the counter counts 0..HALF_x-1;
  - at HALF_x-1 it returns to 0 and the output toggles;
  - period = 2*HALF_x clk cycles, first rising edge HALF_x cycles after reset release.
  - The three dividers are independent; no phase relationship is required.
- Scan index is 2 bits. It increments (wrapping 3→0) on the same clk edge where `clk_500hz` toggles 0→1.
- Digit selection is registered, so `an`/`seg` follow index or BCD input changes with 1-cycle latency:
  - idx 0 → an=1110, digit = `sec_ones`;
  - idx 1 → an=1101, digit = `sec_tens`;
  - idx 2 → an=1011, digit = `min_ones`;
  - idx 3 → an=0111, digit = `min_tens`.
- Decode (`seg`, dp always off, i.e. `seg`[7]=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99;
  - 5=92, 6=82, 7=F8, 8=80, 9=90;
  - values 10–15 → FF (blank digit; `an` still asserted).
- The first cycle after reset release drives an=1110 with `sec_ones` decoded.
- BCD inputs are sampled every cycle; a change mid-scan appears on the next cycle if its digit is active.
- Reset asserted mid-operation forces all outputs and counters to their reset values on that edge, regardless of divider phase.

Decomposition:
- Shared package holds:
  - the ten segment-pattern constants;
  - the blank constant 8'hFF;
  - the four anode one-cold constants.
- One natural sub-module: `clk_divider` (parameter HALF, outputs square wave), instantiated three times.
- Decode and scan stay in the top.

Test Plan:
- Sim parameters HALF_1HZ=20, HALF_5HZ=4, HALF_500HZ=2.
- Reset: hold `rst_n`=0 for 3 cycles → all clk outputs 0, an=1111, seg=FF. Release → next cycle an=1110.
- Divider timing: after release → `clk_500hz` rises at cycle 2 with period 4; `clk_5hz` rises at cycle 4 with period 8; `clk_1hz` rises at cycle 20 with period 40. All 50% duty.
- Scan: inputs mt=1, mo=2, st=3, so=4 → successive `clk_500hz` rising edges give (an,seg):
  - (1110,99), (1101,B0), (1011,A4), (0111,F9);
  - then back to (1110,99).
- Decode sweep: drive `sec_ones` 0..15 while idx=0 → seg = C0,F9,A4,B0,99,92,82,F8,80,90, then FF for 10–15; `seg`[7]=1 always.
- Mid-run reset: assert `rst_n`=0 while idx=2 and `clk_1hz`=1 → next edge all outputs at reset values. After release the scan restarts at idx 0 and `clk_1hz` rises 20 cycles later.
